data_sram_like_slave: RTL
=========================

Name: data_sram_like_slave

Overview:
- Responder end of the SRAM-like data interface used by the CPU's load/store path.
- Accepts requests via req/addr_ok and returns in-order responses via data_ok/rdata after a fixed, parameterised latency, with up to DEPTH requests outstanding.
- Backs the interface with an internal word-addressed memory array.
- Serves as the data-side memory model for pipeline benches and as the front end for a later SRAM-like-to-AXI bridge.

Parameters:
- ADDR_W, 10: word-index width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles from the accept cycle to the data_ok cycle; legal range 1..15.
- DEPTH, 4: maximum outstanding (accepted, not yet responded) requests; legal values are powers of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, not checked.
- data_sram_wstrb  in  4  byte-lane write enables; used only when wr = 1.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_addr_ok  out  1  request accepted this cycle when req = 1.
- data_sram_data_ok  out  1  response valid; the master must consume it, there is no backpressure.
- data_sram_rdata  out  32  read data; 0 on write responses.

Behaviour:
- Word index is addr[ADDR_W+1:2]. addr[1:0] and the upper address bits are ignored, so addresses alias.
- addr_ok = ~reset & (outstanding count < DEPTH). This is conservative: a pop in the same cycle does not free a slot.
- Accept = req & addr_ok.
- Accepted write: bytes whose wstrb bit is set are written into the array at the accept edge. wstrb = 0 is accepted and modifies nothing.
- Accepted read: the array word is sampled at the accept edge and reflects all earlier-accepted writes. The captured word is stored in the response FIFO.
- Same-cycle ordering: a read accepted in the cycle after a write to the same word returns the new data.
- Response FIFO:
  - DEPTH entries, each holding {is_write, data, countdown}.
  - Push at accept with countdown = LATENCY-1.
  - Every valid entry with countdown > 0 decrements each cycle.
  - data_ok = head valid & head countdown == 0. rdata = head data, or 0 if the head is a write.
  - The head pops in the same cycle data_ok is high.
- Timing:
  - A request accepted in cycle T gets data_ok in cycle T+LATENCY exactly, whatever else is outstanding.
  - Responses are in order, at most one per cycle.
  - Sustained throughput is 1 request per cycle when DEPTH >= LATENCY+1.
- When data_ok = 0, rdata holds 0.
- Full: with count == DEPTH, addr_ok = 0 and req is ignored; the master holds req, addr and wdata.
- Simultaneous push and pop: count is unchanged, and pointers wrap modulo DEPTH.
- Empty: data_ok = 0.
- Reset, whether asserted at startup or mid-operation:
  - Next cycle: data_ok = 0, rdata = 0, count = 0, pointers = 0. All outstanding responses are discarded and never returned.
  - addr_ok = 0 while reset = 1, and 1 in the first cycle after reset deasserts.
  - Array contents are not reset; writes accepted before reset persist.
- Outputs after reset: addr_ok = 1 (reset low, FIFO empty), data_ok = 0, rdata = 0.
- Combinational paths: addr_ok depends only on reset and count, never on req. There is no combinational path from req to data_ok.

Test Plan:
- Single read, LATENCY = 2: preload word[5] = 0x11223344, read addr 0x14 accepted at cycle 10 -> data_ok = 1 only in cycle 12, rdata = 0x11223344; rdata = 0 in cycles 11 and 13.
- Partial write then read: word[3] = 0xAABBCCDD, write addr 0x0C, wstrb = 4'b0110, wdata = 0x00123400, immediately followed by a read of 0x0F -> write response has rdata = 0; read response has rdata = 0xAA1234DD.
- Full stall, DEPTH = 4, LATENCY = 8: req held high from cycle 0 -> addr_ok high cycles 0–3, low cycles 4–8; next accept in cycle 9 (the cycle after the first pop in cycle 8); data_ok cycles 8–11 in request order.
- Streaming, LATENCY = 2, DEPTH = 4: 16 back-to-back reads of addresses 0x0..0x3C -> addr_ok never drops; 16 consecutive data_ok pulses starting 2 cycles after the first accept, data in address order.
- Reset mid-flight: 3 reads outstanding, reset high for 1 cycle -> no data_ok from then on; addr_ok = 0 during reset and 1 the cycle after; a prior write to word[7] is still readable.
- LATENCY = 1, DEPTH = 2: alternating write/read to the same word every cycle -> each data_ok arrives in the cycle after its accept, and each read returns the preceding write's data.

Source files
------------

// File: rtl/data_sram_like_slave.sv
// SRAM-like data-port responder: word-addressed memory behind an in-order
// response FIFO that returns each request exactly LATENCY cycles after accept.
module data_sram_like_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

    logic [31:0]       mem [2**ADDR_W];
    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  is_wr;
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        cd_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              pop;

    // size and the non-index address bits carry no meaning here
    wire unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    assign idx               = data_sram_addr[ADDR_W+1:2];
    assign data_sram_addr_ok = ~reset & (count < (PW+1)'(DEPTH));
    assign accept            = data_sram_req & data_sram_addr_ok;
    assign pop               = vld[rd_ptr] & (cd_q[rd_ptr] == 4'd0);
    assign data_sram_data_ok = pop;
    assign data_sram_rdata   = (pop & ~is_wr[rd_ptr]) ? data_q[rd_ptr] : 32'h0;

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b])
                    mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && cd_q[i] != 4'd0)
                    cd_q[i] <= cd_q[i] - 4'd1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            // Read data is captured now, so later writes cannot leak into it.
            if (accept) begin
                vld[wr_ptr]    <= 1'b1;
                is_wr[wr_ptr]  <= data_sram_wr;
                data_q[wr_ptr] <= data_sram_wr ? 32'h0 : mem[idx];
                cd_q[wr_ptr]   <= CD_INIT;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            count <= count + (PW+1)'(accept) - (PW+1)'(pop);
        end
    end
endmodule
